// File: rtl/conv_25_ctrl_pkg.sv
// conv_25_ctrl_pkg: shared constants, state encoding and address helper for the 25-tap conv sequencer
package conv_25_ctrl_pkg;
  localparam int TAPS = 25;
  localparam int ADDR_W = 16;
  localparam int DEF_MEM_LAT = 1;
  localparam int DEF_PIPE_LAT = 1;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, STREAM, DRAIN, DONE} state_t;
  function automatic addr_t to_addr(input int v);
    return addr_t'(v);
  endfunction
endpackage

// File: rtl/conv_25_ctrl_delay.sv
// conv_25_ctrl_delay: sync-reset shift pipe aligning strobes and addresses with datapath latency
module conv_25_ctrl_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;
  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) pipe <= rst ? '0 : d;
    end else begin : g_many
      always_ff @(posedge clk) pipe <= rst ? '0 : {pipe[DEPTH-2:0], d};
    end
  endgenerate
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/conv_25_ctrl.sv
// conv_25_ctrl: job sequencer loading weights, clearing sums, streaming samples and writing results for the 25-tap chain
module conv_25_ctrl
  import conv_25_ctrl_pkg::*;
#(
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic [ADDR_W-1:0] cfg_dbase,
  input  logic [ADDR_W-1:0] cfg_obase,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  output logic              d_rd,
  output logic [ADDR_W-1:0] d_addr,
  output logic              conv_w_en,
  output logic              conv_z_en,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr
);
  state_t state, next;
  logic [ADDR_W-1:0] cnt, len_m1, wbase, dbase, obase, oaddr_src;
  logic cnt_last, short_job, we_src;
  logic [ADDR_W:0] o_pipe;
  assign short_job = cfg_len < to_addr(TAPS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      len_m1 <= '0;
      wbase <= '0;
      dbase <= '0;
      obase <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      cnt <= (state == IDLE || state != next) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        len_m1 <= cfg_len - 1'b1;
        wbase <= cfg_wbase;
        dbase <= cfg_dbase;
        obase <= cfg_obase;
        err <= short_job;
      end
    end
  end
  // CLEAR lasts MEM_LAT+1 cycles so z_en follows the last delayed w_en
  always_comb begin
    cnt_last = (state == LOAD_W) ? cnt == to_addr(TAPS - 1) :
               (state == CLEAR)  ? cnt == to_addr(MEM_LAT) :
               (state == STREAM) ? cnt == len_m1 :
               (state == DRAIN)  ? cnt == to_addr(MEM_LAT + PIPE_LAT - 1) : 1'b0;
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? (short_job ? DONE : LOAD_W) : IDLE;
      LOAD_W:  next = cnt_last ? CLEAR : LOAD_W;
      CLEAR:   next = cnt_last ? STREAM : CLEAR;
      STREAM:  next = cnt_last ? DRAIN : STREAM;
      DRAIN:   next = cnt_last ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    w_rd = state == LOAD_W;
    d_rd = state == STREAM;
    conv_z_en = state == CLEAR && cnt_last;
    w_addr = w_rd ? wbase + cnt : '0;
    d_addr = d_rd ? dbase + cnt : '0;
    we_src = d_rd && cnt >= to_addr(TAPS - 1);
    oaddr_src = we_src ? obase + cnt - to_addr(TAPS - 1) : '0;
  end
  conv_25_ctrl_delay #(.DEPTH(MEM_LAT), .WIDTH(1)) u_wen (
    .clk(clk),
    .rst(rst),
    .d(w_rd),
    .q(conv_w_en)
  );
  conv_25_ctrl_delay #(.DEPTH(MEM_LAT + PIPE_LAT), .WIDTH(ADDR_W + 1)) u_out (
    .clk(clk),
    .rst(rst),
    .d({we_src, oaddr_src}),
    .q(o_pipe)
  );
  assign {o_we, o_addr} = o_pipe;
endmodule
